// File: rtl/game_countdown_if.sv
// Control/overlay bundle for the pre-game countdown: frame timing and game
// requests in, the digit and game flags out.
interface game_countdown_if;
    logic       vblnk;
    logic       start;
    logic       game_over;
    logic [2:0] number;
    logic       is_game_on;
    logic       go;
    logic       counting;

    modport master (
        output vblnk, start, game_over,
        input  number, is_game_on, go, counting
    );

    modport slave (
        input  vblnk, start, game_over,
        output number, is_game_on, go, counting
    );
endinterface

// File: rtl/game_countdown.sv
// Pre-game countdown: steps COUNT_START..1 every STEP_CYCLES clocks, then GAME.
// The digit and game flag seen by the overlay only update on a vblnk rising edge.
module game_countdown #(
    parameter int STEP_CYCLES = 65_000_000,
    parameter int COUNT_START = 3
) (
    input  logic             clk,
    input  logic             rst,
    game_countdown_if.slave  bus
);
    localparam int PW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [2:0]    CNT_INIT   = 3'(COUNT_START);
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, COUNTING, GAME} state_t;

    state_t        state, state_nx;
    logic [2:0]    cnt, cnt_nx;
    logic [PW-1:0] presc, presc_nx;
    logic          vblnk_d, load, tick, go_nx;
    logic [2:0]    number_q;
    logic          is_game_on_q, go_q, counting_q;

    assign tick = (state == COUNTING) && (presc == PRESC_LAST);
    assign load = bus.vblnk & ~vblnk_d;

    // Priority inside COUNTING: game_over, then restart, then tick.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        presc_nx = presc;
        go_nx    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx   = CNT_INIT;
                presc_nx = '0;
                if (bus.start) state_nx = COUNTING;
            end
            COUNTING: begin
                if (bus.game_over) begin
                    state_nx = IDLE;
                    cnt_nx   = CNT_INIT;
                    presc_nx = '0;
                end else if (bus.start) begin
                    cnt_nx   = CNT_INIT;
                    presc_nx = '0;
                end else if (tick) begin
                    presc_nx = '0;
                    if (cnt > 3'd1) begin
                        cnt_nx = cnt - 3'd1;
                    end else begin
                        state_nx = GAME;
                        go_nx    = 1'b1;
                    end
                end else begin
                    presc_nx = presc + 1'b1;
                end
            end
            GAME: begin
                presc_nx = '0;
                if (bus.game_over) begin
                    state_nx = IDLE;
                    cnt_nx   = CNT_INIT;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = CNT_INIT;
                presc_nx = '0;
            end
        endcase
    end

    // Overlay outputs capture the values being committed on this edge, so a
    // tick coinciding with a vblnk rise is shown immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= CNT_INIT;
            presc        <= '0;
            vblnk_d      <= 1'b0;
            go_q         <= 1'b0;
            counting_q   <= 1'b0;
            number_q     <= CNT_INIT;
            is_game_on_q <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            presc      <= presc_nx;
            vblnk_d    <= bus.vblnk;
            go_q       <= go_nx;
            counting_q <= (state_nx == COUNTING);
            if (load) begin
                number_q     <= cnt_nx;
                is_game_on_q <= (state_nx == GAME);
            end
        end
    end

    assign bus.number     = number_q;
    assign bus.is_game_on = is_game_on_q;
    assign bus.go         = go_q;
    assign bus.counting   = counting_q;
endmodule

// File: tb/tb_game_countdown.sv
// Directed + random bench for game_countdown against a time-based reference
// (digit derived from cycles elapsed since the countdown began).
module tb_game_countdown;
    localparam int STEP = 10;
    localparam int CS   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    game_countdown_if bus ();

    game_countdown #(.STEP_CYCLES(STEP), .COUNT_START(CS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int go_cyc = -1;
    bit vb_on = 1'b1;

    // Reference: mode 0=idle 1=counting 2=game; el = cycles spent counting.
    int m_mode, m_el, m_num;
    bit m_vd, m_gon, m_go, m_cnt_o;

    function automatic int m_digit();
        if (m_mode == 1) return CS - m_el / STEP;
        if (m_mode == 2) return 1;
        return CS;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_el = 0; m_num = CS;
        m_vd = 0; m_gon = 0; m_go = 0; m_cnt_o = 0;
    endtask

    task automatic model_update(input bit s, input bit g, input bit v);
        m_go = 0;
        case (m_mode)
            0: if (s) begin m_mode = 1; m_el = 0; end
            1: begin
                if (g) m_mode = 0;
                else if (s) m_el = 0;
                else if (m_el + 1 == CS * STEP) begin m_mode = 2; m_go = 1; end
                else m_el++;
            end
            default: if (g) m_mode = 0;
        endcase
        m_cnt_o = (m_mode == 1);
        if (v && !m_vd) begin
            m_num = m_digit();
            m_gon = (m_mode == 2);
        end
        m_vd = v;
    endtask

    task automatic check(input string tag);
        tests++;
        assert (bus.number === 3'(m_num)) else begin
            fails++; $error("FAIL %s.number got %0d exp %0d", tag, bus.number, m_num);
        end
        tests++;
        assert (bus.is_game_on === m_gon) else begin
            fails++; $error("FAIL %s.is_game_on got %0b exp %0b", tag, bus.is_game_on, m_gon);
        end
        tests++;
        assert (bus.go === m_go) else begin
            fails++; $error("FAIL %s.go got %0b exp %0b", tag, bus.go, m_go);
        end
        tests++;
        assert (bus.counting === m_cnt_o) else begin
            fails++; $error("FAIL %s.counting got %0b exp %0b", tag, bus.counting, m_cnt_o);
        end
    endtask

    function automatic bit vbv();
        return vb_on && (cyc % 4 == 0);
    endfunction

    // Inputs driven at negedge, model advanced at posedge, outputs checked at next negedge.
    task automatic step(input bit s, input bit g, input bit v, input string tag);
        bus.start = s; bus.game_over = g; bus.vblnk = v;
        @(posedge clk);
        model_update(s, g, v);
        cyc++;
        @(negedge clk);
        if (bus.go) go_cyc = cyc;
        check(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, vbv(), tag);
    endtask

    task automatic expect_int(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++; $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    int k;

    initial begin
        bus.start = 0; bus.game_over = 0; bus.vblnk = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset");
        rst = 1'b1;

        // Full countdown with periodic vblnk
        go_cyc = -1;
        step(1, 0, vbv(), "full"); k = cyc;
        run(36, "full");
        expect_int("full.go_latency", go_cyc - k, CS * STEP);
        step(0, 1, vbv(), "end");
        run(8, "end");

        // Frame sync: no vblnk through a whole countdown
        vb_on = 0;
        step(1, 0, 0, "fsync");
        run(36, "fsync");
        step(0, 0, 1, "fsync.rise");
        expect_int("fsync.number", int'(bus.number), 1);
        expect_int("fsync.game_on", int'(bus.is_game_on), 1);
        vb_on = 1;
        step(0, 1, vbv(), "fsync.end");
        run(8, "fsync.end");

        // Restart mid-countdown
        go_cyc = -1;
        step(1, 0, vbv(), "restart");
        run(14, "restart");
        step(1, 0, vbv(), "restart"); k = cyc;
        run(36, "restart");
        expect_int("restart.go_latency", go_cyc - k, CS * STEP);
        step(0, 1, vbv(), "restart.end");
        run(6, "restart.end");

        // Abort during countdown: no go pulse
        go_cyc = -1;
        step(1, 0, vbv(), "abort");
        run(24, "abort");
        step(0, 1, vbv(), "abort");
        run(40, "abort");
        expect_int("abort.no_go", go_cyc, -1);

        // start+game_over in COUNTING, then in GAME, then start alone in GAME
        step(1, 0, vbv(), "simul");
        run(5, "simul");
        step(1, 1, vbv(), "simul.cnt");
        run(6, "simul.cnt");
        step(1, 0, vbv(), "simul");
        run(33, "simul");
        step(1, 1, vbv(), "simul.game");
        run(6, "simul.game");
        step(1, 0, vbv(), "simul");
        run(33, "simul");
        step(1, 0, vbv(), "simul.start_in_game");
        run(6, "simul.start_in_game");
        expect_int("simul.still_game", int'(bus.is_game_on), 1);

        // Async reset mid-countdown (digit 2), vblnk high across release
        step(0, 1, vbv(), "pre_rst");
        step(1, 0, vbv(), "pre_rst");
        run(15, "pre_rst");
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("async_rst");
        bus.start = 0; bus.game_over = 0; bus.vblnk = 1;
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 1, "rst_vblnk");
        run(6, "post_rst");

        // Random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) == 0, "rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/game_countdown.md
Name: game_countdown

Overview:
- Pre-game countdown controller, directly upstream of the single-digit overlay stage.
- Produces the 3-bit digit (number) and the is_game_on flag that the overlay consumes.
- Counts COUNT_START down to 1 at a fixed cycle rate, then asserts is_game_on; returns to idle on game_over.
- Digit/flag outputs change only at the start of vertical blanking, so a digit never tears mid-frame.

Parameters:
- STEP_CYCLES, 65_000_000: clock cycles per countdown step (1 s at 65 MHz); legal range ≥ 2.
- COUNT_START, 3: first digit shown; legal range 1..7.

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- vblnk  in  1  vertical blank from the VGA timing bus
- start  in  1  one-cycle request to begin the countdown
- game_over  in  1  one-cycle request to end the game
- number  out  3  digit to draw; frame-synchronised
- is_game_on  out  1  game running; frame-synchronised
- go  out  1  one-cycle pulse on entry to GAME; not frame-synchronised
- counting  out  1  high while in COUNTING; not frame-synchronised

Behaviour:
- Reset (rst=0, takes effect immediately, asynchronous):
  - state=IDLE, digit register cnt=COUNT_START, prescaler=0, vblnk_d=0.
  - number=COUNT_START, is_game_on=0, go=0, counting=0.
- Prescaler:
  - Width is $clog2(STEP_CYCLES).
  - Counts only in COUNTING; cleared to 0 on every entry to COUNTING and whenever a tick occurs.
  - tick = (prescaler == STEP_CYCLES-1) while in COUNTING.
- State machine (all transitions registered):
  - IDLE:
    - cnt=COUNT_START.
    - start → COUNTING, prescaler=0.
    - game_over ignored.
  - COUNTING:
    - game_over → IDLE, cnt=COUNT_START. game_over wins over start and over tick.
    - Else start → restart: cnt=COUNT_START, prescaler=0, stay in COUNTING.
    - Else tick with cnt>1 → cnt=cnt-1.
    - Else tick with cnt==1 → GAME; go=1 for exactly one cycle; cnt stays 1.
  - GAME:
    - game_over → IDLE, cnt=COUNT_START.
    - start ignored, including when it coincides with game_over.
- counting is a registered state decode: 1 exactly in the cycles where state==COUNTING.
- The countdown lasts COUNT_START×STEP_CYCLES cycles, measured from the cycle after start is sampled to the cycle go is high.
- Frame synchronisation:
  - vblnk_d <= vblnk every cycle; load = vblnk & ~vblnk_d.
  - On load, register number<=cnt and is_game_on<=(next state==GAME). Both capture the values being committed in that same cycle.
  - Between loads, number and is_game_on hold.
  - Latency from an internal change to the outputs: up to one frame, plus one cycle after the vblnk rising edge.
- Boundary conditions:
  - vblnk high while rst is released: the first cycle is treated as a rising edge. The load is harmless, since the values equal the reset values.
  - start held high for several cycles in COUNTING restarts every cycle. The countdown begins from the last sampled start.
  - A tick and a vblnk rise in the same cycle: the output takes the post-tick value.
  - No arithmetic underflow is possible, because cnt never decrements below 1.

Test Plan:
Common settings: STEP_CYCLES=10, COUNT_START=3, vblnk pulsed high for 1 cycle every 4 cycles unless stated.
1. Reset: drive rst=0 asynchronously mid-COUNTING (cnt=2) → number=3, is_game_on=0, go=0, counting=0 before the next clk edge; IDLE after release.
2. Full countdown: start pulse at cycle 0 →
   - internal cnt=2 at cycle 10, cnt=1 at cycle 20;
   - go high only at cycle 30, counting drops at cycle 30;
   - number shows 3,2,1 and is_game_on rises, each ≤5 cycles after the internal change.
3. Frame sync: hold vblnk=0 through a full countdown → number stays 3, is_game_on stays 0. Raise vblnk → next cycle number=1, is_game_on=1.
4. Restart: start again at cycle 15 (cnt=2) → cnt=3; go at cycle 45, not 30.
5. Abort/end:
   - game_over at cycle 25 → IDLE, no go pulse, number=3 after the next vblnk rise.
   - In GAME, game_over → is_game_on=0, number=3 after the next vblnk rise.
6. Simultaneous events:
   - start+game_over in COUNTING → IDLE.
   - start+game_over in GAME → IDLE, counting stays 0.
   - start alone in GAME → no change.
